pc_gen: RTL
===========

# pc_gen

Parametrised fetch-address generator for the IF stage: holds the architectural fetch PC and advances it by a configurable stride. It arbitrates exception and branch/jump redirects by priority, and handshakes each address with the instruction-fetch port (I-cache/AXI bridge). A redirect that arrives while the fetch port is busy or the pipeline is stalled is buffered in a one-entry pending slot. The buffered redirect is applied on the next accepted fetch, so no redirect is lost under backpressure.

## Interface
Parameters:
- `PC_W`, 32, fetch-address width in bits.
- `RST_ADDR`, 32'hBFC0_0000, reset vector; truncated to `PC_W`.
- `STRIDE`, 4, byte increment per accepted fetch; a power of two from 4 to 16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_wr_i`  in  1  pipeline write-enable; 0 = IF stall.
- `pc_ready_i`  in  1  fetch port accepts `pc_o` this cycle.
- `exc_valid_i`  in  1  exception/ERET redirect request from MEM.
- `exc_pc_i`  in  PC_W  exception/ERET target.
- `br_valid_i`  in  1  branch/jump redirect request from ID/EX.
- `br_pc_i`  in  PC_W  branch/jump target.
- `pc_o`  out  PC_W  current fetch address.
- `pc_valid_o`  out  1  `pc_o` is a valid fetch request.
- `pc_redir_o`  out  1  `pc_o` was loaded from a redirect.
- `pc_adel_o`  out  1  `pc_o[1:0] != 0` (address-error on fetch), combinational from `pc_o`.
- `pend_o`  out  1  a redirect is buffered (debug/perf).

## Operation
- **Fire condition:** `fire = pc_valid_o & pc_ready_i & pc_wr_i`.
- **State machine `BOOT → RUN ⇄ PEND`:**
  - BOOT: entered on reset; `pc_valid_o` = 0; unconditionally moves to RUN on the next cycle.
  - RUN: no redirect buffered.
  - PEND: pending slot is occupied.
- **Live redirect:** `exc_valid_i` has priority over `br_valid_i`.
- **Next-PC on fire**, by priority:
  1. live exception target;
  2. live branch target;
  3. pending target;
  4. `pc_o + STRIDE`, modulo 2^PC_W (wrap from max to 0 is legal, no flag).
  - `pc_redir_o` ← 1 for cases 1–3, 0 for case 4.
  - The pending slot is cleared on fire; state → RUN.
- **Redirect without fire:** the target is written to the pending slot; state → PEND.
  - An exception always overwrites the slot.
  - A branch overwrites a pending branch.
  - A branch never overwrites a pending exception.
- **Simultaneous exception and branch:** only the exception is taken or buffered; the branch is dropped.
- **Redirect arriving in BOOT:** buffered. It is applied at the first fire, replacing `RST_ADDR + STRIDE` as the next PC. `RST_ADDR` itself is still issued first.
- **Address stability:** `pc_o` never changes while `pc_valid_o`=1 and no fire occurs; redirects only ever go through the pending slot. `pc_valid_o` stays 1 in RUN and PEND.
- **Reset mid-operation:** any pending redirect is discarded.

## Timing
- **Reset values:**
  - `pc_o` = `RST_ADDR`
  - `pc_valid_o` = 0
  - `pc_redir_o` = 0
  - `pend_o` = 0
  - state = BOOT
- **After reset:** `pc_valid_o` rises one cycle after `rst` deasserts.
- **Redirect latency:** a redirect presented in cycle N with fire in N appears on `pc_o` in N+1. Without fire, it appears in the cycle after the first fire that follows.
- **Outputs:** all registered except `pc_adel_o`. There is no combinational path from `*_valid_i` to `pc_o`.
- **Throughput:** one fetch address per cycle under continuous fire.

## Structure
- Shared package `pc_gen_pkg`:
  - `pc_state_e` (BOOT, RUN, PEND);
  - `redir_t` struct {`valid`, `is_exc`, `pc[PC_W-1:0]`};
  - `RST_ADDR` default constant;
  - `STRIDE` legality check.
- One sub-module, `pc_redirect_buf`: the one-entry pending slot with exception-over-branch overwrite rules. Inputs: live `redir_t`, `fire`, `rst`. Output: pending `redir_t`.
- `pc_gen` contains the FSM, the next-PC mux and the output registers.

## Test plan
- **Reset/boot:** hold `rst` 3 cycles, then release with `pc_ready_i`=`pc_wr_i`=1 → `pc_valid_o`=0 in the first cycle. `pc_o` then reads BFC00000, BFC00004, BFC00008 on consecutive cycles.
- **Branch with fire:** `br_valid_i`=1, `br_pc_i`=80001000 at PC BFC00010 → next `pc_o`=80001000, `pc_redir_o`=1, then 80001004 with `pc_redir_o`=0.
- **Buffered under backpressure:** `pc_ready_i`=0 for 4 cycles while `br_valid_i` pulses once with target 80002000 → `pc_o` stays constant and `pend_o`=1. After the first fire, `pc_o`=80002000 and `pend_o`=0.
- **Priority:**
  - exception (BFC00380) and branch (80003000) in the same stalled cycle → after fire, `pc_o`=BFC00380;
  - a later branch while the exception is pending is ignored;
  - a later exception overwrites a pending branch.
- **Wrap/misalign:** with `PC_W`=32 and `pc_o`=FFFFFFFC, one fire → `pc_o`=00000000. A branch to 80000002 → `pc_adel_o`=1 the cycle that address is on `pc_o`.
- **Reset with pending:** assert `rst` while `pend_o`=1 → after release, `pc_o`=`RST_ADDR` and the pending target is never issued.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the IF-stage fetch-address generator.
// Holds the FSM encoding, the redirect record and the stride legality check.
package pc_gen_pkg;

  localparam int          PC_W_MAX     = 32;
  localparam logic [31:0] RST_ADDR_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  // pc field is sized for the widest supported fetch address; narrower PCs use the low bits
  typedef struct packed {
    logic                valid;
    logic                is_exc;
    logic [PC_W_MAX-1:0] pc;
  } redir_t;

  function automatic bit stride_legal(input int stride);
    return (stride == 4) || (stride == 8) || (stride == 16);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-port handshake between the PC generator (master) and the I-cache/AXI bridge (slave).
interface pc_gen_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_o;
  logic            pc_valid_o;
  logic            pc_redir_o;
  logic            pc_adel_o;
  logic            pc_ready_i;

  modport master (
    output pc_o,
    output pc_valid_o,
    output pc_redir_o,
    output pc_adel_o,
    input  pc_ready_i
  );

  modport slave (
    input  pc_o,
    input  pc_valid_o,
    input  pc_redir_o,
    input  pc_adel_o,
    output pc_ready_i
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect slot; an exception may replace anything, a branch never
// replaces a pending exception.
module pc_redirect_buf
  import pc_gen_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_fire,
  input  redir_t i_live,
  output redir_t o_pend
);

  redir_t r_pend;
  logic   w_accept;

  assign w_accept = i_live.valid & (i_live.is_exc | ~(r_pend.valid & r_pend.is_exc));

  // A live redirect during a fire goes straight to the PC, so the slot only fills on stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (i_fire) begin
      r_pend <= '0;
    end else if (w_accept) begin
      r_pend <= i_live;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch-address generator: stride advance, prioritised redirects and a
// one-entry pending slot so no redirect is lost under fetch backpressure or stall.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter logic [31:0] RST_ADDR = RST_ADDR_DEF,
  parameter int          STRIDE   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_wr_i,
  input  logic            exc_valid_i,
  input  logic [PC_W-1:0] exc_pc_i,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_pc_i,
  pc_gen_if.master        fetch,
  output logic            pend_o
);

  if (!stride_legal(STRIDE)) begin : g_bad_stride
    $error("pc_gen: STRIDE must be 4, 8 or 16");
  end
  if (PC_W < 2 || PC_W > PC_W_MAX) begin : g_bad_pc_w
    $error("pc_gen: PC_W out of supported range");
  end

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_redir;

  logic            w_fire;
  redir_t          w_live;
  redir_t          w_pend;
  logic [PC_W-1:0] w_next_pc;
  logic            w_next_redir;

  assign w_fire = r_valid & fetch.pc_ready_i & pc_wr_i;

  // Exception wins over a same-cycle branch; the losing branch is simply dropped
  always_comb begin
    w_live        = '0;
    w_live.valid  = exc_valid_i | br_valid_i;
    w_live.is_exc = exc_valid_i;
    w_live.pc     = exc_valid_i ? PC_W_MAX'(exc_pc_i) : PC_W_MAX'(br_pc_i);
  end

  pc_redirect_buf u_redirect_buf (
    .clk    (clk),
    .rst    (rst),
    .i_fire (w_fire),
    .i_live (w_live),
    .o_pend (w_pend)
  );

  always_comb begin
    w_next_pc    = r_pc + PC_W'(STRIDE);
    w_next_redir = 1'b0;
    if (w_live.valid) begin
      w_next_pc    = w_live.pc[PC_W-1:0];
      w_next_redir = 1'b1;
    end else if (w_pend.valid) begin
      w_next_pc    = w_pend.pc[PC_W-1:0];
      w_next_redir = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN, PEND: begin
        if (w_fire) begin
          w_state_nxt = RUN;
        end else if (w_live.valid || w_pend.valid) begin
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // pc_o only moves on a fire, which keeps the request stable while the port is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RST_ADDR[PC_W-1:0];
      r_valid <= 1'b0;
      r_redir <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt != BOOT);
      if (w_fire) begin
        r_pc    <= w_next_pc;
        r_redir <= w_next_redir;
      end
    end
  end

  assign fetch.pc_o       = r_pc;
  assign fetch.pc_valid_o = r_valid;
  assign fetch.pc_redir_o = r_redir;
  assign fetch.pc_adel_o  = |r_pc[1:0];
  assign pend_o           = w_pend.valid;

endmodule
